// File: rtl/ram_bank_if.sv
// Port bundle for ram_bank: write port, registered read port, and clear/busy
// control. The master drives requests; the memory bank is the slave.
interface ram_bank_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 256
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic             rd_en;
  logic [AW-1:0]    rd_addr;
  logic [WIDTH-1:0] rd_data;
  logic             rd_valid;
  logic             clear;
  logic             busy;

  modport master (
    output wr_en, wr_addr, wr_data, rd_en, rd_addr, clear,
    input  rd_data, rd_valid, busy
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_en, rd_addr, clear,
    output rd_data, rd_valid, busy
  );
endinterface

// File: rtl/ram_bank.sv
// WIDTH x DEPTH synchronous memory bank: one write port, one registered
// write-first read port, and a sweep sequencer that zeroes the array.
module ram_bank #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 256
) (
  input  logic        clk,
  input  logic        reset_n,
  ram_bank_if.slave   bus
);
  localparam int unsigned AW      = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST  = AW'(DEPTH - 1);

  typedef enum logic {
    INIT = 1'b0,
    IDLE = 1'b1
  } state_e;

  state_e           state_q;
  logic [AW-1:0]    sweep_q;
  logic [WIDTH-1:0] rd_data_q;
  logic             rd_valid_q;
  logic             busy_q;

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic             wr_ok;
  logic             rd_ok;
  logic [WIDTH-1:0] rd_data_d;

  // Addresses at or above DEPTH only exist when DEPTH is not a power of two.
  assign wr_ok = ({1'b0, bus.wr_addr} < DEPTH_W);
  assign rd_ok = ({1'b0, bus.rd_addr} < DEPTH_W);

  always_comb begin
    rd_data_d = '0;
    if (rd_ok) begin
      if (bus.wr_en && (bus.wr_addr == bus.rd_addr))
        rd_data_d = bus.wr_data;
      else
        rd_data_d = mem_q[bus.rd_addr];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= INIT;
      sweep_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      busy_q     <= 1'b1;
    end else begin
      case (state_q)
        INIT: begin
          rd_valid_q <= 1'b0;
          if (bus.clear) begin
            sweep_q <= '0;
          end else if (sweep_q == LAST) begin
            sweep_q <= '0;
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            sweep_q <= sweep_q + AW'(1);
          end
        end
        IDLE: begin
          if (bus.clear) begin
            state_q    <= INIT;
            sweep_q    <= '0;
            busy_q     <= 1'b1;
            rd_valid_q <= 1'b0;
          end else if (bus.rd_en) begin
            rd_data_q  <= rd_data_d;
            rd_valid_q <= 1'b1;
          end else begin
            rd_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q <= INIT;
          sweep_q <= '0;
          busy_q  <= 1'b1;
        end
      endcase
    end
  end

  // Array has no reset; the sweep is the only way it gets initialised.
  always_ff @(posedge clk) begin
    if (state_q == INIT)
      mem_q[sweep_q] <= '0;
    else if (bus.wr_en && !bus.clear && wr_ok)
      mem_q[bus.wr_addr] <= bus.wr_data;
  end

  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.busy     = busy_q;
endmodule

// File: doc/ram_bank.md
# ram_bank

Parametrised synchronous memory bank: the generalisation of the fixed 1-bit and 16-bit storage registers into a WIDTH x DEPTH array. It has one write port, one registered read port, and a hardware clear sequencer. It forms the main-memory building block of the computer's memory subsystem, with addressing, latency and initialisation fixed here so CPU-side logic has no dependence on array size.

## Interface
- WIDTH, 16, data word width in bits (>= 1)
- DEPTH, 256, number of words (>= 2; need not be a power of two)
- AW, $clog2(DEPTH), address width (derived; not overridden)
- clk  in  1  system clock; all state changes on rising edge
- reset_n  in  1  reset, asynchronous assert, active-low; one clock, reset is asynchronous and active-low
- wr_en  in  1  write request
- wr_addr  in  AW  write address
- wr_data  in  WIDTH  write data
- rd_en  in  1  read request
- rd_addr  in  AW  read address
- rd_data  out  WIDTH  registered read data
- rd_valid  out  1  one-cycle pulse: rd_data updated this cycle
- clear  in  1  request to zero the whole array
- busy  out  1  clear sweep in progress; port requests ignored

## Operation
- Two states: INIT (clear sweep) and IDLE (normal access).
- INIT
  - Entered on reset assertion, or from IDLE when clear=1 at a rising edge.
  - Internal counter sweep_addr starts at 0.
  - Each rising edge writes 0 to mem[sweep_addr] and increments sweep_addr.
  - The edge that writes mem[DEPTH-1] moves to IDLE.
  - clear=1 while in INIT restarts sweep_addr at 0.
  - wr_en and rd_en are ignored; no write occurs, rd_valid stays 0, rd_data holds.
- IDLE, write: wr_en=1 at an edge stores wr_data into mem[wr_addr].
- IDLE, read: rd_en=1 at an edge loads mem[rd_addr] into rd_data and drives rd_valid=1 for that cycle.
- IDLE, no read: rd_en=0 leaves rd_data holding its last value and drives rd_valid=0.
- Read-during-write to the same address in the same cycle is write-first: rd_data gets the new wr_data.
- Out-of-range address (addr >= DEPTH, possible only when DEPTH is not a power of two):
  - Write is dropped with no side effects.
  - Read returns all zeros with rd_valid=1.
- clear=1 in IDLE together with wr_en/rd_en: clear wins. The edge enters INIT, the write is dropped and no read is performed.
- busy = 1 exactly while in INIT.

## Timing
- Reset values (asynchronous, while reset_n=0):
  - rd_data = 0, rd_valid = 0, busy = 1.
  - State INIT with sweep_addr = 0.
  - Array contents are not reset directly.
- After reset release, busy stays 1 for exactly DEPTH rising edges, then falls after the DEPTH-th edge. The first port access is accepted on edge DEPTH+1.
- A clear sampled in IDLE at edge N: busy=1 after edge N. Zeros are written on edges N+1 .. N+DEPTH; busy=0 after edge N+DEPTH.
- Read latency: request sampled at edge N, data and rd_valid visible after edge N, one cycle.
- Back-to-back reads every cycle are supported, with rd_valid held high continuously.
- Write latency: data written at edge N is readable by a read sampled at edge N (bypass) or any later edge.
- Reset mid-sweep or mid-access: immediate return to the reset values above. The sweep restarts from address 0 after release.

## Test plan
- WIDTH=16, DEPTH=8 (bench default unless stated). Release reset -> busy=1 for exactly 8 edges, then 0. Afterwards, reads of addr 0..7 return 0x0000 with one rd_valid pulse each.
- In IDLE: write 0xA5A5 to addr 3, then read addr 3 on the next edge -> rd_data=0xA5A5 and rd_valid=1 one cycle after the read request. A read of addr 4 returns 0x0000.
- Same-edge write 0x1234 and read, both at addr 5 -> rd_data=0x1234 after that edge. Then rd_en=0 for 3 cycles -> rd_data holds 0x1234 and rd_valid=0.
- Fill addr 0..7 with 0xFFFF, then clear=1 with wr_en=1 (addr 2, 0x0F0F) on the same edge:
  - busy=1 for 8 edges.
  - wr_en/rd_en during the sweep produce no write and no rd_valid.
  - All 8 words then read 0x0000.
- DEPTH=6: write 0xBEEF to addr 7 -> dropped. Read addr 7 -> 0x0000 with rd_valid=1. Addr 5 is unchanged.
- Assert reset_n=0 mid-sweep (after edge 4 of 8) and mid-read -> rd_data=0 and rd_valid=0 immediately. After release, busy=1 for a full 8 edges again.
